// File: rtl/layer_out_serializer.sv
// layer_out_serializer: captures one activation per neuron lane as each lane
// pulses its valid bit, then streams the captured layer out one word per
// cycle (stalled by hold) to feed the next layer's serial input.
// Optional feature: define ARGMAX_EN to track the index of the largest
// (signed) streamed activation; without it argmax_idx/argmax_valid are 0.
module layer_out_serializer #(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0]   neuron_out,
  input  logic [NUM_NEURONS-1:0]              neuron_valid,
  input  logic                                hold,
  output logic [DATA_WIDTH-1:0]               data_out,
  output logic                                data_valid,
  output logic                                busy,
  output logic                                overflow,
  output logic [$clog2(NUM_NEURONS)-1:0]      argmax_idx,
  output logic                                argmax_valid
);

  localparam int IDXW = $clog2(NUM_NEURONS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_NEURONS - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_STREAM  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [NUM_NEURONS-1:0] flags_q, flags_d, flags_merged;
  logic [IDXW-1:0]        idx_q, idx_d;
  // Set once the last word has been emitted: STREAM lingers one extra cycle
  // so the return to IDLE (and the argmax result) land on the following edge.
  logic                   drain_q, drain_d;
  logic                   capturing;
  logic                   emit;
  logic                   finish;
  logic [DATA_WIDTH-1:0]  lane_buf [NUM_NEURONS];

  assign busy = (state_q != S_IDLE);

  // Next-state, flag and index computation
  always_comb begin
    capturing    = (state_q != S_STREAM);
    flags_merged = flags_q | neuron_valid;
    state_d      = state_q;
    flags_d      = flags_q;
    idx_d        = idx_q;
    drain_d      = drain_q;
    emit         = 1'b0;
    finish       = 1'b0;
    case (state_q)
      S_IDLE, S_CAPTURE: begin
        if (&flags_merged) begin
          state_d = S_STREAM;
          flags_d = '0;
          idx_d   = '0;
          drain_d = 1'b0;
        end else begin
          flags_d = flags_merged;
          if (|neuron_valid) state_d = S_CAPTURE;
        end
      end
      S_STREAM: begin
        if (drain_q) begin
          finish  = 1'b1;
          state_d = S_IDLE;
          drain_d = 1'b0;
          idx_d   = '0;
        end else if (!hold) begin
          emit = 1'b1;
          if (idx_q == LAST_IDX) drain_d = 1'b1;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      flags_q <= '0;
      idx_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
    end
  end

  // Lane capture buffer; pulses arriving while streaming are dropped
  always_ff @(posedge clk) begin
    if (capturing) begin
      for (int unsigned k = 0; k < NUM_NEURONS; k++) begin
        if (neuron_valid[k]) lane_buf[k] <= neuron_out[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Serial output word, valid strobe and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      data_valid <= emit;
      if (emit) data_out <= lane_buf[idx_q];
      if ((state_q == S_STREAM) && (|neuron_valid)) overflow <= 1'b1;
    end
  end

`ifdef ARGMAX_EN
  logic signed [DATA_WIDTH-1:0] cur_word;
  logic signed [DATA_WIDTH-1:0] max_q;
  logic [IDXW-1:0]              max_idx_q;

  assign cur_word = lane_buf[idx_q];

  // Running signed maximum over emitted words; strict '>' keeps the lowest index on ties
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q        <= '0;
      max_idx_q    <= '0;
      argmax_idx   <= '0;
      argmax_valid <= 1'b0;
    end else begin
      argmax_valid <= 1'b0;
      if (emit && ((idx_q == '0) || (cur_word > max_q))) begin
        max_q     <= cur_word;
        max_idx_q <= idx_q;
      end
      if (finish) begin
        argmax_idx   <= max_idx_q;
        argmax_valid <= 1'b1;
      end
    end
  end
`else
  assign argmax_idx   = '0;
  assign argmax_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_out_serializer.sv
// Testbench for layer_out_serializer (NUM_NEURONS=4): directed scenarios plus
// randomized traffic, compared every cycle against a queue-based reference.
module tb_layer_out_serializer;

  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*DW-1:0] neuron_out = '0;
  logic [N-1:0]    neuron_valid = '0;
  logic            hold = 1'b0;
  logic [DW-1:0]   data_out;
  logic            data_valid;
  logic            busy;
  logic            overflow;
  logic [1:0]      argmax_idx;
  logic            argmax_valid;

  int n_cmp = 0;
  int n_err = 0;

  layer_out_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .neuron_out   (neuron_out),
    .neuron_valid (neuron_valid),
    .hold         (hold),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .busy         (busy),
    .overflow     (overflow),
    .argmax_idx   (argmax_idx),
    .argmax_valid (argmax_valid)
  );

  always #5 clk = ~clk;

  // Reference model: captured words, lanes seen, and a queue of words to stream
  logic [DW-1:0] mbuf [N];
  logic [N-1:0]  mgot;
  logic [DW-1:0] wq [$];
  bit            m_stream;
  int            m_best;
  bit            dout_known;
  logic [DW-1:0] e_dout;
  logic          e_dv, e_busy, e_ovf, e_av;
  logic [1:0]    e_aidx;

  task automatic model_reset();
    mgot = '0;
    wq.delete();
    m_stream = 0;
    m_best = 0;
    dout_known = 1;
    e_dout = '0;
    e_dv = 0; e_busy = 0; e_ovf = 0; e_av = 0; e_aidx = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] nv, input logic [N*DW-1:0] vals, input logic h);
    e_av = 0;
    if (m_stream) begin
      dout_known = 0;
      if (|nv) e_ovf = 1;
      if (wq.size() == 0) begin
        m_stream = 0;
        e_busy = 0;
        e_dv = 0;
`ifdef ARGMAX_EN
        e_aidx = 2'(m_best);
        e_av = 1;
`endif
      end else if (h) begin
        e_dv = 0;
      end else begin
        e_dout = wq.pop_front();
        e_dv = 1;
      end
    end else begin
      e_dv = 0;
      for (int k = 0; k < N; k++) begin
        if (nv[k]) begin
          mbuf[k] = vals[k*DW +: DW];
          mgot[k] = 1'b1;
        end
      end
      if (&mgot) begin
        m_best = 0;
        for (int k = 1; k < N; k++)
          if ($signed(mbuf[k]) > $signed(mbuf[m_best])) m_best = k;
        for (int k = 0; k < N; k++) wq.push_back(mbuf[k]);
        mgot = '0;
        m_stream = 1;
        e_busy = 1;
      end else if (mgot != '0) begin
        e_busy = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("data_valid", 32'(data_valid), 32'(e_dv));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("overflow", 32'(overflow), 32'(e_ovf));
    chk("argmax_idx", 32'(argmax_idx), 32'(e_aidx));
    chk("argmax_valid", 32'(argmax_valid), 32'(e_av));
    if (e_dv || dout_known) chk("data_out", 32'(data_out), 32'(e_dout));
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model at the edge
  task automatic step(input logic [N-1:0] nv, input logic [N*DW-1:0] vals,
                      input logic h, input logic r);
    neuron_valid = nv;
    neuron_out   = vals;
    hold         = h;
    rst          = r;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (r) model_reset();
    else   model_edge(nv, vals, h);
    #1;
  endtask

  function automatic logic [N*DW-1:0] rvals();
    return {$urandom, $urandom};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, rvals(), 1'b0, 1'b0);
  endtask

  localparam logic [N*DW-1:0] LAYER_A = {16'h0001, 16'h7FFF, 16'hFF00, 16'h0100};
  localparam logic [N*DW-1:0] LAYER_T = {16'h0003, 16'h0005, 16'h8000, 16'h0005};

  initial begin
    logic [N-1:0] nv;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then idle cycles with junk on unqualified lanes
    idle(3);

    // All lanes together, no stall
    step(4'hF, LAYER_A, 1'b0, 1'b0);
    idle(8);

    // Lanes trickle in one at a time, lane 3 last after a long gap
    step(4'b0001, rvals(), 1'b0, 1'b0);
    idle(1);
    step(4'b0010, rvals(), 1'b0, 1'b0);
    idle(1);
    step(4'b0100, rvals(), 1'b0, 1'b0);
    idle(10);
    step(4'b1000, rvals(), 1'b0, 1'b0);
    idle(8);

    // Two-cycle stall in the middle of the stream
    step(4'hF, LAYER_A, 1'b0, 1'b0);
    idle(2);
    step('0, rvals(), 1'b1, 1'b0);
    step('0, rvals(), 1'b1, 1'b0);
    idle(8);

    // Stray pulse while streaming raises sticky overflow
    step(4'hF, LAYER_A, 1'b0, 1'b0);
    idle(2);
    step(4'b0010, rvals(), 1'b0, 1'b0);
    idle(10);

    // Reset mid-stream, then a fresh pass
    step(4'hF, LAYER_A, 1'b0, 1'b0);
    idle(2);
    step('0, rvals(), 1'b0, 1'b1);
    idle(3);
    step(4'hF, rvals(), 1'b0, 1'b0);
    idle(8);

    // Tie on the maximum, and a negative extreme
    step(4'hF, LAYER_T, 1'b0, 1'b0);
    idle(8);

    // Re-pulsed lane overwrites its earlier capture
    step(4'b0001, {48'h0, 16'h1111}, 1'b0, 1'b0);
    step(4'b0001, {48'h0, 16'h2222}, 1'b0, 1'b0);
    step(4'b1110, rvals(), 1'b0, 1'b0);
    idle(8);

    // Randomized traffic with stalls, stray pulses and occasional resets
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) nv[k] = ($urandom_range(3) == 0);
      if (m_stream && ($urandom_range(15) != 0)) nv = '0;
      step(nv, rvals(), ($urandom_range(2) == 0), ($urandom_range(200) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/layer_out_serializer.md
LAYER_OUT_SERIALIZER -- requirements
Module: layer_out_serializer

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 30: number of parallel neuron lanes captured per layer pass (≥2).
REQ-002 SHALL have parameter DATA_WIDTH, default 16: width of one neuron activation, signed two's complement.
REQ-003 SHALL have port clk, input, 1: clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port neuron_out, input, NUM_NEURONS*DATA_WIDTH: lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-006 SHALL have port neuron_valid, input, NUM_NEURONS: bit k is a one-cycle pulse qualifying lane k.
REQ-007 SHALL have port hold, input, 1: stall request from the downstream layer.
REQ-008 SHALL have port data_out, output, DATA_WIDTH: serialized activation, registered.
REQ-009 SHALL have port data_valid, output, 1: qualifies data_out, registered; drives next-layer myinputValid.
REQ-010 SHALL have port busy, output, 1: high in CAPTURE or STREAM.
REQ-011 SHALL have port overflow, output, 1: sticky error flag.
REQ-012 SHALL have port argmax_idx, output, $clog2(NUM_NEURONS): index of the largest activation.
REQ-013 SHALL have port argmax_valid, output, 1: one-cycle pulse qualifying argmax_idx.

Function
REQ-014 SHALL implement FSM states IDLE, CAPTURE, STREAM.
REQ-015 In IDLE or CAPTURE, each sampled neuron_valid[k] SHALL store lane k into buf[k] and set flag[k]; a repeated pulse on a flagged lane SHALL overwrite buf[k].
REQ-016 IDLE SHALL go to CAPTURE on any sampled neuron_valid bit unless the transition to STREAM applies.
REQ-017 CAPTURE or IDLE SHALL go to STREAM at the edge where all flags, including lanes captured at that edge, are set; flags SHALL clear at that edge.
REQ-018 In STREAM, an index counter from 0 SHALL advance at each edge with hold=0, registering data_out=buf[idx] and data_valid=1.
REQ-019 At an edge in STREAM with hold=1, data_valid SHALL register 0 and idx SHALL hold; data_out is don't-care.
REQ-020 After emitting idx=NUM_NEURONS-1, FSM SHALL return to IDLE and data_valid SHALL register 0 at the next edge.
REQ-021 Latency: if the last lane pulses in cycle T with hold=0 throughout, words 0..N-1 SHALL appear in cycles T+2..T+N+1 with data_valid continuously high.
REQ-022 Any neuron_valid bit sampled while in STREAM SHALL be dropped and SHALL set overflow, which stays set until rst.
REQ-023 busy SHALL equal (state != IDLE), combinational from the state register.
REQ-024 Neuron lanes that never pulse SHALL keep FSM in CAPTURE indefinitely; no timeout.

Reset
REQ-025 rst SHALL force state=IDLE, idx=0, all flags=0, data_out=0, data_valid=0, overflow=0, argmax_idx=0, argmax_valid=0; buf contents are don't-care.
REQ-026 rst asserted mid-CAPTURE or mid-STREAM SHALL abort the pass with no further data_valid and no argmax_valid.

Configuration
REQ-027 Macro ARGMAX_EN defined: during STREAM, a running signed maximum over emitted words SHALL be tracked, ties resolved to the lowest index; argmax_idx SHALL update and argmax_valid pulse for one cycle at the edge after the last word is emitted.
REQ-028 Macro ARGMAX_EN undefined: comparator logic SHALL be absent; argmax_idx and argmax_valid SHALL be constant 0.

Verification
REQ-029 NUM_NEURONS=4, lanes {0x0100,0xFF00,0x7FFF,0x0001} pulsed together in cycle 10, hold=0 -> data_valid high cycles 12-15 with data_out 0x0100,0xFF00,0x7FFF,0x0001; busy low from cycle 16.
REQ-030 Lanes pulsed in cycles 5,7,9,20 (lane 3 last) -> busy high from cycle 6, first word in cycle 22, order lane 0..3.
REQ-031 hold=1 during cycles 13-14 of scenario REQ-029 -> data_valid low in cycles 14-15, words resume in order, last word in cycle 17, no word lost or repeated.
REQ-032 neuron_valid[1] pulsed in cycle 13 of scenario REQ-029 -> overflow high from cycle 14 until rst, streamed values unchanged.
REQ-033 rst in cycle 13 of scenario REQ-029 -> data_valid 0 from cycle 14, all outputs 0; new pass afterwards streams correctly.
REQ-034 ARGMAX_EN defined, lanes {0x0005,0x8000,0x0005,0x0003} -> argmax_idx=0 with argmax_valid single pulse the cycle after the last word; undefined -> both stay 0.
